cache_arbiter_ctrl: RTL and testbench
=====================================

# cache_arbiter_ctrl

Sequencing controller that sits in front of the single-port `cache` block. It shares that cache between two requesters (port 0: fetch, port 1: load/store) using round-robin arbitration. It sequences each access as lookup → hit check → miss fill from backing memory → response. Writes are write-through: the cache and memory are both updated before the requester is acknowledged. It also keeps hit and miss counters for performance monitoring.

## Interface
- `AW`, default 16, address width.
- `DW`, default 16, data width.
- `CW`, default 16, counter width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  request valid; held until the matching ack.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read; held with req.
- `p0_addr`, `p1_addr`  in  AW  request address; held with req.
- `p0_wdata`, `p1_wdata`  in  DW  write data; held with req.
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse.
- `p0_rdata`, `p1_rdata`  out  DW  read data; valid in the ack cycle.
- `read1`  out  AW  cache read address.
- `r1e`  out  1  cache read enable.
- `write1`  out  AW  cache write address.
- `writedata`  out  DW  cache write data.
- `w1e`  out  1  cache write enable.
- `readHit`  in  1  cache hit flag.
- `readout1`  in  DW  cache read data.
- `m_req`  out  1  memory request; held until m_ack.
- `m_we`  out  1  memory write.
- `m_addr`  out  AW  memory address.
- `m_wdata`  out  DW  memory write data.
- `m_ack`  in  1  memory completion; m_rdata valid in the same cycle.
- `m_rdata`  in  DW  memory read data.
- `hit_cnt`, `miss_cnt`  out  CW  read hit and miss counters.

## Operation
Cache contract: the cache samples `read1`/`r1e` on a rising edge; `readHit`/`readout1` are valid during the following cycle. A write is performed at the edge where `w1e` = 1.

States: IDLE, LOOKUP, CHECK, MEM_RD, FILL, WR_CACHE, WR_MEM, RESP.
- **IDLE:** `p0_req`/`p1_req` are sampled only in this state.
  - If one request is high, it is granted.
  - If both are high, the port not granted last wins. The last-grant register resets to port 1, so port 0 wins the first tie.
  - Address, we and wdata are latched into internal registers.
  - Next state is LOOKUP for a read, WR_CACHE for a write.
- **LOOKUP:** `r1e` = 1, `read1` = latched address, for exactly one cycle. Next state is CHECK.
- **CHECK:**
  - If `readHit` = 1: capture `readout1` into the response register, increment `hit_cnt`, go to RESP.
  - Otherwise: increment `miss_cnt`, go to MEM_RD.
- **MEM_RD:** `m_req` = 1, `m_we` = 0, `m_addr` = latched address. These are held until `m_ack`. On `m_ack`, capture `m_rdata` and go to FILL.
- **FILL:** `w1e` = 1, `write1` = address, `writedata` = captured fill data, for one cycle. The response register holds the fill data. Next state is RESP.
- **WR_CACHE:** `w1e` = 1 with the latched address and data, for one cycle. Next state is WR_MEM.
- **WR_MEM:** `m_req` = 1, `m_we` = 1, `m_addr`/`m_wdata` = latched values, held until `m_ack`. Then go to RESP.
- **RESP:**
  - The granted port's ack = 1 for one cycle.
  - That port's rdata = response register. For a write, rdata keeps its previous value.
  - Then go to IDLE.
- A requester must drop req in the cycle after ack. A req still high when IDLE is next entered is treated as a new request.
- `m_ack` is ignored when `m_req` = 0.
- Counters wrap modulo 2^CW. Writes do not count.
- Outputs `r1e`, `w1e`, `m_req`, `m_we` and the acks are registered from state. They are never asserted simultaneously except as listed above.

## Timing
- Reset (asynchronous, `rst_n` = 0):
  - State goes to IDLE; last grant goes to port 1.
  - All outputs go to 0: acks, rdata, `r1e`, `w1e`, `read1`, `write1`, `writedata`, memory outputs, both counters.
  - A transaction in flight is abandoned with no ack. `m_req` falls immediately.
- Request with req high in cycle t (state IDLE):
  - Read hit: LOOKUP at t+1, CHECK at t+2, ack at t+3.
  - Read miss with `m_ack` at t+3+k (k ≥ 0): FILL at t+4+k, ack at t+5+k.
  - Write with `m_ack` at t+2+k: ack at t+3+k.
- Back-to-back: the next grant can occur at the cycle after RESP. Minimum spacing is 4 cycles between hit acks.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-MEM_RD → `m_req`, acks and counters read 0 at once. After release, state is IDLE and no ack is issued.
- **Read hit:** port 0 reads addr 1, which the cache holds as 343 (`readHit` = 1) → `p0_ack` at t+3, `p0_rdata` = 343, `hit_cnt` = 1.
- **Read miss:** port 1 reads addr 128 with `readHit` = 0; memory returns 0x1234 after 3 wait cycles → one `w1e` pulse with `write1` = 128, `writedata` = 0x1234, then `p1_ack` with `p1_rdata` = 0x1234, `miss_cnt` = 1.
- **Write-through:** port 0 writes 343 to addr 16 → one `w1e` cycle, then `m_req`/`m_we` held until `m_ack`, then `p0_ack`. `hit_cnt` and `miss_cnt` are unchanged.
- **Arbitration:** both ports request continuously, each dropping req after ack and reasserting → grants alternate 0, 1, 0, 1. No port is acked twice in a row.
- **Counter wrap:** with `CW` = 4, perform 17 hits → `hit_cnt` = 1.

Source files
------------

// File: rtl/cache_arbiter_ctrl.sv
// Round-robin front end for a single-port cache: lookup, hit check, miss fill
// from backing memory, write-through, and hit/miss performance counters.
module cache_arbiter_ctrl #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p1_req,
  input  logic          p0_we,
  input  logic          p1_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_ack,
  output logic          p1_ack,
  output logic [DW-1:0] p0_rdata,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] read1,
  output logic          r1e,
  output logic [AW-1:0] write1,
  output logic [DW-1:0] writedata,
  output logic          w1e,
  input  logic          readHit,
  input  logic [DW-1:0] readout1,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic [CW-1:0] hit_cnt,
  output logic [CW-1:0] miss_cnt
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, CHECK, MEM_RD, FILL, WR_CACHE, WR_MEM, RESP
  } state_t;

  state_t        state, next_state;
  logic          grant_q, last_q, we_q;
  logic          grant_d, take;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, resp_q, rdata_d;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  // On a tie the port that was not served last wins; last_q resets to port 1.
  assign grant_d   = (p0_req && p1_req) ? ~last_q : p1_req;
  assign req_we    = grant_d ? p1_we    : p0_we;
  assign req_addr  = grant_d ? p1_addr  : p0_addr;
  assign req_wdata = grant_d ? p1_wdata : p0_wdata;

  // Hit data comes straight off the cache; fill data was captured at m_ack.
  assign rdata_d   = (state == CHECK) ? readout1 : resp_q;

  assign read1     = addr_q;
  assign write1    = addr_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign writedata = (state == FILL) ? resp_q : wdata_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          take       = 1'b1;
          next_state = req_we ? WR_CACHE : LOOKUP;
        end
      end
      LOOKUP:   next_state = CHECK;
      CHECK:    next_state = readHit ? RESP : MEM_RD;
      MEM_RD:   if (m_ack) next_state = FILL;
      FILL:     next_state = RESP;
      WR_CACHE: next_state = WR_MEM;
      WR_MEM:   if (m_ack) next_state = RESP;
      RESP:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      r1e      <= 1'b0;
      w1e      <= 1'b0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= next_state;
      if (take) begin
        grant_q <= grant_d;
        last_q  <= grant_d;
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == CHECK) begin
        if (readHit) begin
          resp_q  <= readout1;
          hit_cnt <= hit_cnt + CW'(1);
        end else begin
          miss_cnt <= miss_cnt + CW'(1);
        end
      end
      if (state == MEM_RD && m_ack) resp_q <= m_rdata;

      // Strobes are registered from the state being entered.
      r1e    <= (next_state == LOOKUP);
      w1e    <= (next_state == FILL) || (next_state == WR_CACHE);
      m_req  <= (next_state == MEM_RD) || (next_state == WR_MEM);
      m_we   <= (next_state == WR_MEM);
      p0_ack <= (next_state == RESP) && !grant_q;
      p1_ack <= (next_state == RESP) &&  grant_q;
      if (next_state == RESP && !we_q) begin
        if (grant_q) p1_rdata <= rdata_d;
        else         p0_rdata <= rdata_d;
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter_ctrl.sv
// Self-checking bench: cache and memory environment models plus a
// transaction-timeline reference model compared against the DUT every cycle.
module tb_cache_arbiter_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]    req, we_v;
  logic [AW-1:0] addr_v  [2];
  logic [DW-1:0] wdata_v [2];
  logic          p0_ack, p1_ack, r1e, w1e, m_req, m_we;
  logic [DW-1:0] p0_rdata, p1_rdata, writedata, m_wdata;
  logic [AW-1:0] read1, write1, m_addr;
  logic          readHit, m_ack;
  logic [DW-1:0] readout1, m_rdata;
  logic [CW-1:0] hit_cnt, miss_cnt;

  cache_arbiter_ctrl #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p1_req(req[1]), .p0_we(we_v[0]), .p1_we(we_v[1]),
    .p0_addr(addr_v[0]), .p1_addr(addr_v[1]),
    .p0_wdata(wdata_v[0]), .p1_wdata(wdata_v[1]),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .read1(read1), .r1e(r1e), .write1(write1), .writedata(writedata), .w1e(w1e),
    .readHit(readHit), .readout1(readout1),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t q0[$], q1[$];
  int   ack_order[$];

  // Environment: backing memory and cache contents.
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] cdat [256];
  logic          cval [256];
  logic          look_pend, mem_busy, rand_mode;
  logic [7:0]    look_addr;
  int            mem_wait, mem_lat;

  // Reference model: the transaction in flight and its observed milestones.
  logic          tx_active, tx_we, tx_hit;
  int            tx_port, tx_t0, tx_tack;
  logic [AW-1:0] tx_addr;
  logic [DW-1:0] tx_wdata, tx_data;
  int            last_gnt, model_hit, model_miss;
  logic [DW-1:0] exp_rdata [2];
  logic          drop [2];

  int cyc, checks, failures;
  int last_grant_cyc, last_ack_cyc, acks_seen, w1e_cnt;
  logic [AW-1:0] last_w1_addr;
  logic [DW-1:0] last_w1_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    tx_active = 1'b0; tx_hit = 1'b0; tx_tack = -1;
    last_gnt = 1; model_hit = 0; model_miss = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    drop[0] = 1'b0; drop[1] = 1'b0;
    req = '0; we_v = '0;
    q0.delete(); q1.delete();
    look_pend = 1'b0; mem_busy = 1'b0;
    m_ack = 1'b0; readHit = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_req"}, m_req, 0);
    check({tag, "_acks"}, {p1_ack, p0_ack}, 0);
    check({tag, "_strobes"}, {r1e, w1e, m_we}, 0);
    check({tag, "_hit_cnt"}, hit_cnt, 0);
    check({tag, "_miss_cnt"}, miss_cnt, 0);
    check({tag, "_rdata"}, {p1_rdata, p0_rdata}, 0);
    check({tag, "_buses"}, {read1 | write1 | m_addr, writedata | m_wdata}, 0);
  endtask

  // Reset asserted from the current point in the cycle; checked at once.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs({tag, "_held"});
    rst_n = 1'b1;
  endtask

  task automatic step();
    logic e_r1e, e_w1e, e_mreq, e_mwe, ack_cycle;
    logic [1:0] e_ack;
    int d, g;
    req_t r;
    @(posedge clk);
    #1;
    cyc++;
    {e_r1e, e_w1e, e_mreq, e_mwe, ack_cycle} = '0;
    e_ack = '0;

    if (tx_active) begin
      d = cyc - tx_t0;
      if (!tx_we) begin
        if (d == 3) begin
          if (tx_hit) model_hit  = (model_hit  + 1) % (1 << CW);
          else        model_miss = (model_miss + 1) % (1 << CW);
        end
        if (d == 1) e_r1e = 1'b1;
        else if (tx_hit && d == 3) ack_cycle = 1'b1;
        else if (!tx_hit && d >= 3) begin
          if (tx_tack < 0)             e_mreq = 1'b1;
          else if (cyc == tx_tack + 1) e_w1e = 1'b1;
          else if (cyc == tx_tack + 2) ack_cycle = 1'b1;
        end
      end else begin
        if (d == 1) e_w1e = 1'b1;
        else if (tx_tack < 0) begin e_mreq = 1'b1; e_mwe = 1'b1; end
        else if (cyc == tx_tack + 1) ack_cycle = 1'b1;
      end
    end
    if (ack_cycle) begin
      e_ack[tx_port] = 1'b1;
      if (!tx_we) exp_rdata[tx_port] = tx_data;
    end

    check("r1e", r1e, e_r1e);
    check("w1e", w1e, e_w1e);
    check("m_req", m_req, e_mreq);
    check("m_we", m_we, e_mwe);
    check("acks", {p1_ack, p0_ack}, e_ack);
    check("hit_cnt", hit_cnt, model_hit);
    check("miss_cnt", miss_cnt, model_miss);
    if (e_r1e) check("read1", read1, tx_addr);
    if (e_w1e) begin
      check("write1", write1, tx_addr);
      check("writedata", writedata, tx_we ? tx_wdata : tx_data);
    end
    if (e_mreq) check("m_addr", m_addr, tx_addr);
    if (e_mreq && tx_we) check("m_wdata", m_wdata, tx_wdata);
    if (ack_cycle) check("rdata", tx_port ? p1_rdata : p0_rdata, exp_rdata[tx_port]);

    if (p0_ack) ack_order.push_back(0);
    if (p1_ack) ack_order.push_back(1);
    if (p0_ack || p1_ack) begin last_ack_cyc = cyc; acks_seen++; end

    // Cache environment.
    if (w1e) begin
      cdat[write1[7:0]] = writedata;
      cval[write1[7:0]] = 1'b1;
      w1e_cnt++;
      last_w1_addr = write1;
      last_w1_data = writedata;
    end
    if (look_pend) begin
      readHit  = cval[look_addr];
      readout1 = readHit ? cdat[look_addr] : DW'($urandom);
      if (tx_active && !tx_we && cyc == tx_t0 + 2) begin
        tx_hit  = readHit;
        tx_data = readout1;
      end
      look_pend = 1'b0;
    end else begin
      readHit  = rand_mode ? 1'($urandom) : 1'b0;
      readout1 = DW'($urandom);
    end
    if (r1e) begin look_pend = 1'b1; look_addr = read1[7:0]; end
    if (rand_mode && $urandom_range(0, 15) == 0) cval[$urandom_range(0, 31)] = 1'b0;

    // Memory environment.
    if (m_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 4));
      end
      if (mem_wait == 0) begin
        m_ack = 1'b1;
        if (m_we) begin mem[m_addr[7:0]] = m_wdata; m_rdata = DW'($urandom); end
        else m_rdata = mem[m_addr[7:0]];
        mem_busy = 1'b0;
        if (tx_active && e_mreq) begin
          tx_tack = cyc;
          if (!tx_we) tx_data = m_rdata;
        end
      end else begin
        mem_wait--;
        m_ack = 1'b0;
      end
    end else begin
      mem_busy = 1'b0;
      m_ack    = rand_mode ? ($urandom_range(0, 7) == 0) : 1'b0;
      m_rdata  = DW'($urandom);
    end

    // Requesters: hold until ack, drop the cycle after, then maybe reissue.
    for (int p = 0; p < 2; p++) begin
      if (drop[p]) begin
        req[p] = 1'b0;
        drop[p] = 1'b0;
      end else if (ack_cycle && tx_port == p) begin
        drop[p] = 1'b1;
      end else if (!req[p] && ((p == 0) ? q0.size() : q1.size()) != 0 &&
                   (!rand_mode || $urandom_range(0, 2) == 0)) begin
        r = (p == 0) ? q0.pop_front() : q1.pop_front();
        req[p] = 1'b1; we_v[p] = r.we; addr_v[p] = r.addr; wdata_v[p] = r.wdata;
      end
    end

    // Grant decision for a cycle the controller spends idle.
    if (ack_cycle) begin
      tx_active = 1'b0;
    end else if (!tx_active && req != 2'b00) begin
      g = (req == 2'b11) ? 1 - last_gnt : (req[1] ? 1 : 0);
      last_gnt = g;
      tx_active = 1'b1; tx_port = g; tx_we = we_v[g];
      tx_addr = addr_v[g]; tx_wdata = wdata_v[g];
      tx_t0 = cyc; tx_hit = 1'b0; tx_tack = -1; tx_data = '0;
      last_grant_cyc = cyc;
    end
  endtask

  task automatic run_until_done(input string name, input int max_cycles);
    int n = 0;
    logic busy;
    busy = 1'b1;
    while (busy && n < max_cycles) begin
      step();
      n++;
      busy = (q0.size() != 0) || (q1.size() != 0) || (req != 2'b00) ||
             tx_active || drop[0] || drop[1];
    end
    check({name, "_completed"}, !busy, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    int n;
    checks = 0; failures = 0; cyc = 0;
    rand_mode = 1'b0; mem_lat = 0; acks_seen = 0; w1e_cnt = 0;
    readout1 = '0; m_rdata = '0;
    addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = DW'($urandom); cdat[i] = '0; cval[i] = 1'b0;
    end
    mem[128] = 16'h1234;
    model_reset();
    rst_n = 1'b0;
    #2;
    apply_reset("reset");

    // Read hit: port 0, addr 1 holds 343.
    cval[1] = 1'b1; cdat[1] = 16'd343;
    q0.push_back('{we: 1'b0, addr: 16'd1, wdata: 16'd0});
    run_until_done("hit", 30);
    check("hit_rdata", p0_rdata, 16'd343);
    check("hit_count", hit_cnt, 1);
    check("hit_latency", last_ack_cyc - last_grant_cyc, 3);

    // Read miss: port 1, addr 128, memory answers after 3 wait cycles.
    mem_lat = 3; w1e_cnt = 0;
    q1.push_back('{we: 1'b0, addr: 16'd128, wdata: 16'd0});
    run_until_done("miss", 40);
    check("miss_rdata", p1_rdata, 16'h1234);
    check("miss_count", miss_cnt, 1);
    check("miss_fill_pulses", w1e_cnt, 1);
    check("miss_fill_addr", last_w1_addr, 16'd128);
    check("miss_fill_data", last_w1_data, 16'h1234);
    check("miss_latency", last_ack_cyc - last_grant_cyc, 8);

    // Write-through: port 0 writes 343 to addr 16.
    mem_lat = 2; w1e_cnt = 0;
    q0.push_back('{we: 1'b1, addr: 16'd16, wdata: 16'd343});
    run_until_done("write", 40);
    check("wr_cache_pulses", w1e_cnt, 1);
    check("wr_cache_data", cdat[16], 16'd343);
    check("wr_mem_data", mem[16], 16'd343);
    check("wr_latency", last_ack_cyc - last_grant_cyc, 5);
    check("wr_rdata_kept", p0_rdata, 16'd343);
    check("wr_counts", {24'd0, hit_cnt, miss_cnt}, {24'd0, 4'd1, 4'd1});

    // Reset in the middle of a memory read.
    mem_lat = 20; cval[200] = 1'b0;
    q1.push_back('{we: 1'b0, addr: 16'd200, wdata: 16'd0});
    n = 0;
    do begin step(); n++; end while (!m_req && n < 10);
    check("mid_mreq_seen", m_req, 1);
    check("mid_miss_before", miss_cnt, 2);
    apply_reset("mid_reset");
    acks_seen = 0;
    repeat (8) step();
    check("mid_no_ack", acks_seen, 0);

    // Arbitration: both ports keep requesting; first tie goes to port 0.
    mem_lat = 0;
    for (int a = 2; a < 6; a++) begin cval[a] = 1'b1; cdat[a] = 16'(100 + a); end
    ack_order.delete();
    q0.push_back('{we: 1'b0, addr: 16'd2, wdata: 16'd0});
    q0.push_back('{we: 1'b0, addr: 16'd3, wdata: 16'd0});
    q1.push_back('{we: 1'b0, addr: 16'd4, wdata: 16'd0});
    q1.push_back('{we: 1'b0, addr: 16'd5, wdata: 16'd0});
    run_until_done("arb", 60);
    check("arb_count", ack_order.size(), 4);
    for (int i = 0; i < 4 && i < ack_order.size(); i++)
      check($sformatf("arb_order%0d", i), ack_order[i], i % 2);
    check("arb_last_p0", p0_rdata, 16'd103);
    check("arb_last_p1", p1_rdata, 16'd105);

    // Counter wrap: 17 hits with a 4-bit counter.
    @(posedge clk); #1;
    apply_reset("wrap_reset");
    cval[7] = 1'b1; cdat[7] = 16'h0777;
    for (int i = 0; i < 17; i++) begin
      r = '{we: 1'b0, addr: 16'd7, wdata: 16'd0};
      if (i % 2 == 0) q0.push_back(r); else q1.push_back(r);
    end
    run_until_done("wrap", 200);
    check("wrap_hit_cnt", hit_cnt, 1);
    check("wrap_miss_cnt", miss_cnt, 0);

    // Randomized traffic with random memory latency and stray inputs.
    rand_mode = 1'b1; mem_lat = -1;
    for (int i = 0; i < 300; i++) begin
      r.we    = ($urandom_range(0, 2) == 0);
      r.addr  = 16'($urandom_range(0, 31));
      r.wdata = DW'($urandom);
      if (i % 2 == 0) q0.push_back(r); else q1.push_back(r);
    end
    run_until_done("random", 20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
